seg7_display_arbiter: RTL and testbench
=======================================

// Module: seg7_display_arbiter
// PURPOSE
//   Shares the single 4-digit seven-segment display between two requesters, A and B.
//   Example requesters: the scroll message source and the adder-result source.
//   Sits between the requesters and seg7_driver, and drives seg7_driver's value and anode_d inputs.
//   Enforces a minimum and a maximum dwell time, counted in slow ticks from slow_clkgen.
//   Arbitrates round-robin when both requesters want the display.
// PARAMETERS
//   W         16  display value width (4 hex digits)
//   MIN_HOLD  2   minimum ticks an owner keeps the display (1 <= MIN_HOLD <= MAX_HOLD)
//   MAX_HOLD  8   ticks after which a contested owner is pre-empted
// PORTS
//   clk      in   1   system clock; all state changes on its rising edge
//   rst      in   1   asynchronous, active-high reset
//   tick     in   1   single-cycle enable pulse (slow_clkgen rate); advances dwell counter
//   req_a    in   1   requester A wants the display (level)
//   value_a  in   W   A's hex value
//   mask_a   in   4   A's digit blank mask (1 = digit off)
//   req_b    in   1   requester B wants the display (level)
//   value_b  in   W   B's hex value
//   mask_b   in   4   B's digit blank mask
//   gnt_a    out  1   A currently owns the display and is still requesting
//   gnt_b    out  1   B currently owns the display and is still requesting
//   value    out  W   to seg7_driver value
//   anode_d  out  4   to seg7_driver anode_d; 1 = digit blanked
//   busy     out  1   state != IDLE
// BEHAVIOUR
//   Reset (async, immediate, also mid-operation):
//     state=IDLE, gnt_a=gnt_b=0, value=0, anode_d=4'b1111, busy=0, dwell=0, last=B.
//   FSM states: IDLE, OWN_A, OWN_B. All outputs are registered.
//   IDLE:
//     req_a&req_b -> owner is the requester not equal to last (A first after reset).
//     Single request -> that requester. Neither -> stay IDLE.
//     Grant visible one clk after req is sampled. anode_d=4'b1111; value holds its last contents.
//   Entering OWN_X: dwell=0; last<=X; value<=value_X; anode_d<=mask_X.
//   OWN_X, each clk:
//     req_X=1 -> value/anode_d track value_X/mask_X with 1 clk latency; gnt_X=1.
//     req_X=0 -> gnt_X=0 on the next edge; value/anode_d freeze (display stays readable).
//     tick=1 -> dwell increments, saturating at MAX_HOLD.
//   Exit test uses the registered dwell value (before this cycle's tick). Exit when dwell>=MIN_HOLD and either:
//     (a) req_X=0: go to OWN_Y if req_Y, else IDLE.
//     (b) req_Y=1 and dwell>=MAX_HOLD: go to OWN_Y (pre-emption). gnt_X drops and gnt_Y rises on the same edge.
//   No contention: the owner holds indefinitely while requesting; dwell saturates.
//   gnt_a and gnt_b are never high together. At most one grant changes per edge, except at a direct handover.
//   dwell counter width is $clog2(MAX_HOLD+1).
//   tick is ignored in IDLE.
//   req dropping then reasserting before MIN_HOLD: ownership is kept and gnt re-rises on the next edge.
// TESTING
//   Reset test: assert rst mid-OWN_A.
//     -> Same cycle (async): gnt_a=0, anode_d=4'hF, value=0, busy=0.
//   Single request: req_a=1, value_a=16'h1234, mask_a=0.
//     -> Next edge: gnt_a=1, value=16'h1234, anode_d=4'h0.
//     -> Change value_a to 16'hBEEF: value updates 1 clk later.
//   Minimum hold: OWN_A, drop req_a after 0 ticks.
//     -> gnt_a=0 next edge; value stays 16'hBEEF.
//     -> IDLE (anode_d=4'hF) only after 2 ticks.
//   Simultaneous request: req_a=req_b=1 from IDLE after reset.
//     -> gnt_a first.
//     -> After a later A release and B release, the next tie goes to A again only if last=B.
//   Pre-emption: A holds while req_b=1.
//     -> After the 8th tick's following edge: gnt_a=0, gnt_b=1, value=value_b.
//   Back-to-back handover: A releases with req_b high.
//     -> OWN_A goes straight to OWN_B with no IDLE cycle; anode_d never shows 4'hF.

Source files
------------

// File: rtl/seg7_display_arbiter_if.sv
// seg7_display_arbiter_if: requester/display bundle; master = requester side (req/value/mask out, gnt/value/anode_d/busy in), slave = arbiter side
interface seg7_display_arbiter_if #(parameter int W = 16);
  logic         req_a;
  logic [W-1:0] value_a;
  logic [3:0]   mask_a;
  logic         req_b;
  logic [W-1:0] value_b;
  logic [3:0]   mask_b;
  logic         gnt_a;
  logic         gnt_b;
  logic [W-1:0] value;
  logic [3:0]   anode_d;
  logic         busy;
  modport master (output req_a, value_a, mask_a, req_b, value_b, mask_b, input gnt_a, gnt_b, value, anode_d, busy);
  modport slave (input req_a, value_a, mask_a, req_b, value_b, mask_b, output gnt_a, gnt_b, value, anode_d, busy);
endinterface

// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter: round-robin owner of the 4-digit display with min/max dwell in ticks; ports clk, rst (async high), tick, bus (slave: req/value/mask in, gnt/value/anode_d/busy out)
module seg7_display_arbiter #(
  parameter int W = 16,
  parameter int MIN_HOLD = 2,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst,
  input logic tick,
  seg7_display_arbiter_if.slave bus
);
  localparam int DW = $clog2(MAX_HOLD + 1);
  localparam logic [DW-1:0] MIN_D = DW'(MIN_HOLD);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_HOLD);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state, nxt;
  logic [DW-1:0] dwell, dwell_d;
  logic last_b, last_b_d;
  logic gnt_a_q, gnt_b_q, busy_q, gnt_a_d, gnt_b_d, busy_d;
  logic [W-1:0] value_q, value_d;
  logic [3:0] anode_q, anode_d_d;
  logic own_req, oth_req, leave, take_a, take_b;
  assign own_req = state == OWN_A ? bus.req_a : bus.req_b;
  assign oth_req = state == OWN_A ? bus.req_b : bus.req_a;
  // exit decision uses the registered dwell, so a tick on this edge cannot shorten the hold
  assign leave = dwell >= MIN_D && (!own_req || (oth_req && dwell >= MAX_D));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      dwell <= '0;
      last_b <= 1'b1;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q <= 1'b0;
      value_q <= '0;
      anode_q <= 4'hF;
    end else begin
      state <= nxt;
      dwell <= dwell_d;
      last_b <= last_b_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      busy_q <= busy_d;
      value_q <= value_d;
      anode_q <= anode_d_d;
    end
  always_comb begin
    nxt = state;
    if (state == IDLE)
      nxt = bus.req_a && (!bus.req_b || last_b) ? OWN_A : bus.req_b ? OWN_B : IDLE;
    else if (leave)
      nxt = !oth_req ? IDLE : state == OWN_A ? OWN_B : OWN_A;
  end
  always_comb begin
    take_a = nxt == OWN_A && bus.req_a;
    take_b = nxt == OWN_B && bus.req_b;
    gnt_a_d = take_a;
    gnt_b_d = take_b;
    busy_d = nxt != IDLE;
    // an owner that stops requesting keeps its last picture on screen
    value_d = take_a ? bus.value_a : take_b ? bus.value_b : value_q;
    anode_d_d = nxt == IDLE ? 4'hF : take_a ? bus.mask_a : take_b ? bus.mask_b : anode_q;
    dwell_d = nxt != state ? '0 : (state != IDLE && tick && dwell != MAX_D) ? dwell + 1'b1 : dwell;
    last_b_d = nxt == OWN_B ? 1'b1 : nxt == OWN_A ? 1'b0 : last_b;
  end
  assign bus.gnt_a = gnt_a_q;
  assign bus.gnt_b = gnt_b_q;
  assign bus.busy = busy_q;
  assign bus.value = value_q;
  assign bus.anode_d = anode_q;
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb_seg7_display_arbiter: directed scoreboard bench for seg7_display_arbiter
module tb_seg7_display_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string tag;
    logic ga;
    logic gb;
    logic [15:0] v;
    logic [3:0] an;
    logic bz;
  } exp_t;
  exp_t q[$];
  seg7_display_arbiter_if #(.W(16)) bus ();
  seg7_display_arbiter #(.W(16), .MIN_HOLD(2), .MAX_HOLD(8)) dut (.clk(clk), .rst(rst), .tick(tick), .bus(bus));
  always #5 clk = ~clk;
  task automatic check_head();
    exp_t e;
    e = q.pop_front();
    checks++;
    assert ({bus.gnt_a, bus.gnt_b, bus.value, bus.anode_d, bus.busy} === {e.ga, e.gb, e.v, e.an, e.bz})
    else begin
      errors++;
      $error("FAIL %s: got gnt_a=%b gnt_b=%b value=%h anode_d=%h busy=%b, expected gnt_a=%b gnt_b=%b value=%h anode_d=%h busy=%b",
             e.tag, bus.gnt_a, bus.gnt_b, bus.value, bus.anode_d, bus.busy, e.ga, e.gb, e.v, e.an, e.bz);
    end
  endtask
  task automatic expect_now(input string tag, input logic ga, input logic gb, input logic [15:0] v, input logic [3:0] an, input logic bz);
    q.push_back('{tag, ga, gb, v, an, bz});
    check_head();
  endtask
  task automatic step(input string tag, input logic ra, input logic rb, input logic t,
                      input logic ga, input logic gb, input logic [15:0] v, input logic [3:0] an, input logic bz);
    bus.req_a = ra;
    bus.req_b = rb;
    tick = t;
    q.push_back('{tag, ga, gb, v, an, bz});
    @(posedge clk);
    #1;
    check_head();
  endtask
  initial begin
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.value_a = '0;
    bus.mask_a = '0;
    bus.value_b = '0;
    bus.mask_b = '0;
    #12;
    expect_now("reset_state", 0, 0, 16'h0, 4'hF, 0);
    rst = 1'b0;
    bus.value_a = 16'h1234;
    bus.mask_a = 4'h0;
    step("grant_a", 1, 0, 0, 1, 0, 16'h1234, 4'h0, 1);
    bus.value_a = 16'hBEEF;
    step("track_a", 1, 0, 0, 1, 0, 16'hBEEF, 4'h0, 1);
    step("drop_a", 0, 0, 0, 0, 0, 16'hBEEF, 4'h0, 1);
    step("min_hold_t1", 0, 0, 1, 0, 0, 16'hBEEF, 4'h0, 1);
    step("min_hold_t2", 0, 0, 1, 0, 0, 16'hBEEF, 4'h0, 1);
    step("idle_after_min", 0, 0, 0, 0, 0, 16'hBEEF, 4'hF, 0);
    bus.value_a = 16'h1111;
    step("regrant_a", 1, 0, 0, 1, 0, 16'h1111, 4'h0, 1);
    #2;
    rst = 1'b1;
    #1;
    expect_now("async_reset", 0, 0, 16'h0, 4'hF, 0);
    bus.req_a = 1'b0;
    #1;
    rst = 1'b0;
    step("idle_after_rst", 0, 0, 0, 0, 0, 16'h0, 4'hF, 0);
    bus.value_a = 16'hAAAA;
    bus.mask_a = 4'h1;
    bus.value_b = 16'hBBBB;
    bus.mask_b = 4'h2;
    step("tie_a_first", 1, 1, 0, 1, 0, 16'hAAAA, 4'h1, 1);
    for (int i = 0; i < 8; i++)
      step($sformatf("hold_%0d", i), 1, 1, 1, 1, 0, 16'hAAAA, 4'h1, 1);
    step("preempt", 1, 1, 0, 0, 1, 16'hBBBB, 4'h2, 1);
    step("b_rel_t1", 1, 0, 1, 0, 0, 16'hBBBB, 4'h2, 1);
    step("b_rel_t2", 1, 0, 1, 0, 0, 16'hBBBB, 4'h2, 1);
    step("handover", 1, 0, 0, 1, 0, 16'hAAAA, 4'h1, 1);
    step("a_blip", 0, 0, 0, 0, 0, 16'hAAAA, 4'h1, 1);
    bus.value_a = 16'hCCCC;
    step("a_rerise", 1, 0, 0, 1, 0, 16'hCCCC, 4'h1, 1);
    step("a_rel_t1", 0, 0, 1, 0, 0, 16'hCCCC, 4'h1, 1);
    step("a_rel_t2", 0, 0, 1, 0, 0, 16'hCCCC, 4'h1, 1);
    step("a_idle", 0, 0, 0, 0, 0, 16'hCCCC, 4'hF, 0);
    step("tie_b_after_a", 1, 1, 0, 0, 1, 16'hBBBB, 4'h2, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
